// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM states, the per-cycle operation
// selected by strobe priority, and the fetch-path widths.
package pc_seq_pkg;

  localparam int PC_W      = 12;
  localparam int LUT_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcs_state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_HALT = 3'd1,
    OP_RET  = 3'd2,
    OP_CALL = 3'd3,
    OP_JMP  = 3'd4,
    OP_REL  = 3'd5,
    OP_INC  = 3'd6
  } pc_op_t;

  // Only the highest-priority strobe acts; everything below it is dropped.
  function automatic pc_op_t decode_op(input logic stall, input logic halt,
                                       input logic ret,   input logic call,
                                       input logic jmp,   input logic rel);
    if (stall)     return OP_HOLD;
    else if (halt) return OP_HALT;
    else if (ret)  return OP_RET;
    else if (call) return OP_CALL;
    else if (jmp)  return OP_JMP;
    else if (rel)  return OP_REL;
    else           return OP_INC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. The pointer counts occupied entries (0..DEPTH), so it
// carries one extra bit to tell full from empty. Entries are not reset; only
// the pointer is, which is enough since nothing is read above the pointer.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int D     = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [D-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [D-1:0] top_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [D-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_m1;

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign ptr_m1  = ptr_q - PW'(1);
  assign top_o   = mem_q[ptr_m1[AW-1:0]];

  // Pointer next state: clear wins, then guarded push, then guarded pop.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)                  ptr_d = '0;
    else if (push_i && !full_o) ptr_d = ptr_q + PW'(1);
    else if (pop_i && !empty_o) ptr_d = ptr_m1;
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Storage write at the current pointer on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !clr_i) mem_q[ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller for the fetch path: owns the PC, runs the
// IDLE/RUN/DONE FSM, and sequences +1 / relative branch / LUT jump /
// call / return. The LUT index passes straight through to the LUT.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D           = PC_W,
  parameter int STACK_DEPTH = 4,
  parameter int OFF_W       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [D-1:0]         StartAddr,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Jump,
  input  logic                 BranchRel,
  input  logic [OFF_W-1:0]     Offset,
  input  logic                 Call,
  input  logic                 Ret,
  input  logic [LUT_IDX_W-1:0] LutIdx,
  output logic [LUT_IDX_W-1:0] LutAddr,
  input  logic [D-1:0]         LutTarget,
  output logic [D-1:0]         PC,
  output logic                 Running,
  output logic                 Done,
  output logic                 StackErr
);

  pcs_state_t   state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         err_q, err_d;
  logic         stk_push, stk_pop, stk_clr;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_top;
  logic [D-1:0] pc_inc, off_ext;
  pc_op_t       op;

  assign pc_inc  = pc_q + D'(1);
  assign off_ext = {{(D-OFF_W){Offset[OFF_W-1]}}, Offset};
  assign op      = decode_op(Stall, Halt, Ret, Call, Jump, BranchRel);

  ret_stack #(.DEPTH(STACK_DEPTH), .D(D)) u_stack (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (stk_clr),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_inc),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .top_o   (stk_top)
  );

  // FSM next state, next PC and stack control; faults end the program.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          err_d   = 1'b0;
          stk_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        case (op)
          OP_HOLD: ;
          OP_HALT: state_d = DONE;
          OP_RET: begin
            if (stk_empty) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end
          end
          OP_CALL: begin
            if (stk_full) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              stk_push = 1'b1;
              pc_d     = LutTarget;
            end
          end
          OP_JMP:  pc_d = LutTarget;
          OP_REL:  pc_d = pc_q + off_ext;
          OP_INC:  pc_d = pc_inc;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign PC       = pc_q;
  assign Running  = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign StackErr = err_q;
  assign LutAddr  = LutIdx;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, halt, jump, brel, call, ret;
  logic [11:0] start_addr;
  logic [7:0]  offset;
  logic [4:0]  lut_idx, lut_addr;
  logic [11:0] lut_target, pc;
  logic        running, done, stack_err;

  logic [11:0] lut [32];
  assign lut_target = lut[lut_addr];

  pc_sequencer dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .StartAddr(start_addr),
    .Stall(stall), .Halt(halt), .Jump(jump), .BranchRel(brel), .Offset(offset),
    .Call(call), .Ret(ret), .LutIdx(lut_idx), .LutAddr(lut_addr),
    .LutTarget(lut_target), .PC(pc), .Running(running), .Done(done),
    .StackErr(stack_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: 0=idle, 1=run, 2=done
  int m_pc, m_state, m_ptr;
  bit m_err;
  int m_stk [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_state = 0; m_ptr = 0; m_err = 1'b0;
  endtask

  // Apply one clock edge worth of the program-counter rules.
  task automatic model_edge(input bit st, input int sa, input bit stl, input bit hlt,
                            input bit jmp, input bit rel, input int off,
                            input bit cl, input bit rt, input int idx);
    if (m_state != 1) begin
      if (st) begin m_pc = sa; m_ptr = 0; m_err = 1'b0; m_state = 1; end
    end else if (stl) begin
    end else if (hlt) begin
      m_state = 2;
    end else if (rt) begin
      if (m_ptr == 0) begin m_err = 1'b1; m_state = 2; end
      else begin m_ptr--; m_pc = m_stk[m_ptr]; end
    end else if (cl) begin
      if (m_ptr == 4) begin m_err = 1'b1; m_state = 2; end
      else begin m_stk[m_ptr] = (m_pc + 1) % 4096; m_ptr++; m_pc = lut[idx]; end
    end else if (jmp) begin
      m_pc = lut[idx];
    end else if (rel) begin
      m_pc = (m_pc + off) & 4095;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
  endtask

  task automatic step(input bit st = 0, input int sa = 0, input bit stl = 0,
                      input bit hlt = 0, input bit jmp = 0, input bit rel = 0,
                      input int off = 0, input bit cl = 0, input bit rt = 0,
                      input int idx = 0);
    start = st; start_addr = 12'(sa); stall = stl; halt = hlt; jump = jmp;
    brel = rel; offset = 8'(off); call = cl; ret = rt; lut_idx = 5'(idx);
    @(posedge clk);
    model_edge(st, sa, stl, hlt, jmp, rel, off, cl, rt, idx);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", int'(pc), m_pc);
      chk("running", int'(running), int'(m_state == 1));
      chk("done", int'(done), int'(m_state == 2));
      chk("stack_err", int'(stack_err), int'(m_err));
      chk("lut_addr", int'(lut_addr), int'(lut_idx));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 12'((i * 137 + 3) % 4096);
    lut[1] = 12'd40; lut[2] = 12'd196; lut[3] = 12'd10; lut[4] = 12'd20;
    lut[6] = 12'd4090;
    start = 0; start_addr = 0; stall = 0; halt = 0; jump = 0; brel = 0;
    offset = 0; call = 0; ret = 0; lut_idx = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk_en = 1'b1;

    // T1 reset / start / increment
    do_reset();
    chk("t1_rst_pc", int'(pc), 0);
    chk("t1_rst_run", int'(running), 0);
    chk("t1_rst_done", int'(done), 0);
    step(.st(1), .sa(5));
    chk("t1_start_pc", int'(pc), 5);
    chk("t1_start_run", int'(running), 1);
    repeat (3) step();
    chk("t1_inc_pc", int'(pc), 8);
    chk("t1_model_pc", m_pc, 8);

    // T2 LUT jump, negative relative branch
    step(.jmp(1), .idx(3));
    chk("t2_pc10", int'(pc), 10);
    lut_idx = 5'd1; #1;
    chk("t2_lutaddr", int'(lut_addr), 1);
    step(.jmp(1), .idx(1));
    chk("t2_jump", int'(pc), 40);
    step(.rel(1), .off(-5));
    chk("t2_rel", int'(pc), 35);

    // T3 call / return
    step(.jmp(1), .idx(4));
    step(.cl(1), .idx(2));
    chk("t3_call", int'(pc), 196);
    repeat (2) step();
    chk("t3_run", int'(pc), 198);
    step(.rt(1));
    chk("t3_ret", int'(pc), 21);
    chk("t3_model_ret", m_pc, 21);

    // T4 overflow on fifth nested call
    for (int i = 0; i < 4; i++) step(.cl(1), .idx(8 + i));
    step(.cl(1), .idx(12));
    chk("t4_err", int'(stack_err), 1);
    chk("t4_done", int'(done), 1);
    chk("t4_pc", int'(pc), int'(lut[11]));
    step(.st(1), .sa(100));
    chk("t4_clr", int'(stack_err), 0);

    // T5 underflow, Halt over Jump, Stall over Jump
    step(.rt(1));
    chk("t5_uflow", int'(stack_err), 1);
    chk("t5_pc", int'(pc), 100);
    step(.st(1), .sa(50));
    step(.hlt(1), .jmp(1), .idx(1));
    chk("t5_halt_done", int'(done), 1);
    chk("t5_halt_pc", int'(pc), 50);
    step(.st(1), .sa(60));
    step(.stl(1), .jmp(1), .idx(1));
    chk("t5_stall_pc", int'(pc), 60);
    chk("t5_stall_run", int'(running), 1);

    // T6 wrap and mid-run reset
    step(.hlt(1));
    step(.st(1), .sa(4095));
    step();
    chk("t6_wrap", int'(pc), 0);
    step(.jmp(1), .idx(6));
    step(.rel(1), .off(20));
    chk("t6_relwrap", int'(pc), 14);
    do_reset();
    chk("t6_rst_pc", int'(pc), 0);
    chk("t6_rst_run", int'(running), 0);

    // Randomised program flow against the model
    step(.st(1), .sa(int'($urandom_range(0, 4095))));
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (m_state != 1 && r < 30)
        step(.st(1), .sa(int'($urandom_range(0, 4095))));
      else
        step(.st($urandom_range(0, 9) == 0), .sa(int'($urandom_range(0, 4095))),
             .stl($urandom_range(0, 9) == 0), .hlt($urandom_range(0, 39) == 0),
             .jmp($urandom_range(0, 5) == 0), .rel($urandom_range(0, 4) == 0),
             .off(int'($urandom_range(0, 255)) - 128),
             .cl($urandom_range(0, 6) == 0), .rt($urandom_range(0, 6) == 0),
             .idx(int'($urandom_range(0, 31))));
      if (n == 1500) do_reset();
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
